// File: rtl/velocity_cell_stream_ctrl_pkg.sv
// Shared constants for the velocity cell stream controller: FSM encoding,
// velocity word field layout and the RAM address holding the particle count.
package velocity_cell_stream_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_CNT   = 3'd1;
    localparam logic [2:0] ST_WAIT_CNT = 3'd2;
    localparam logic [2:0] ST_STREAM   = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // velocity word layout {vz,vy,vx}, FP32 each
    localparam int VX_LSB = 0;
    localparam int VX_MSB = 31;
    localparam int VY_LSB = 32;
    localparam int VY_MSB = 63;
    localparam int VZ_LSB = 64;
    localparam int VZ_MSB = 95;

    localparam int COUNT_ADDR = 0;

    function automatic logic [95:0] pack_vel(input logic [31:0] vx,
                                             input logic [31:0] vy,
                                             input logic [31:0] vz);
        logic [95:0] v;
        v = '0;
        v[VX_MSB:VX_LSB] = vx;
        v[VY_MSB:VY_LSB] = vy;
        v[VZ_MSB:VZ_LSB] = vz;
        return v;
    endfunction

endpackage

// File: rtl/velocity_cell_stream_ctrl_if.sv
// Bus bundle between the controller and its environment: single-port RAM,
// outbound velocity stream and inbound write-back channel.
interface velocity_cell_stream_ctrl_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;

    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_index;
    logic [DATA_WIDTH-1:0] out_vel;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [ADDR_WIDTH-1:0] wb_index;
    logic [DATA_WIDTH-1:0] wb_vel;

    // controller side
    modport master (
        output mem_address, mem_data, mem_rden, mem_wren,
        input  mem_q,
        output out_valid, out_index, out_vel,
        input  out_ready,
        input  wb_valid, wb_index, wb_vel,
        output wb_ready
    );

    // RAM + motion-update side
    modport slave (
        input  mem_address, mem_data, mem_rden, mem_wren,
        output mem_q,
        input  out_valid, out_index, out_vel,
        output out_ready,
        output wb_valid, wb_index, wb_vel,
        input  wb_ready
    );

endinterface

// File: rtl/velocity_cell_stream_ctrl_fifo2.sv
// Two-entry FIFO with occupancy output. Push and pop may happen in the
// same cycle; head is the oldest entry and is only meaningful when count!=0.
module vel_stream_fifo2 #(
    parameter int W = 104
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [1:0][W-1:0] mem;
    logic              wp;
    logic              rp;
    logic [1:0]        cnt;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);
    assign head    = mem[rp];
    assign count   = cnt;

    // storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem <= '0;
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wp] <= push_data;
                wp      <= ~wp;
            end
            if (do_pop)
                rp <= ~rp;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/velocity_cell_stream_ctrl.sv
// Velocity cell stream controller: reads the particle count from RAM word 0,
// streams words 1..N through a 2-entry buffer with backpressure, and writes
// motion-update results back through the same single RAM port. Write-backs
// always win the port over streaming reads.
module velocity_cell_stream_ctrl
    import velocity_cell_stream_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] particle_count,
    velocity_cell_stream_ctrl_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);
    // one stage: RAM returns data the cycle after rden
    localparam int STAGES = 0;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] index;
        logic [DATA_WIDTH-1:0] vel;
    } ent_t;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] cnt_n;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [ADDR_WIDTH:0]   wb_cnt;
    logic [STAGES:0]       vld_pipe;
    logic [1:0]            fifo_cnt;
    logic [2:0]            occ;
    logic [ADDR_WIDTH-1:0] q_cnt;
    logic                  wb_fire;
    logic                  wb_ok;
    logic                  wr_en;
    logic                  rd_issue;
    logic                  pop;
    ent_t                  push_ent;
    ent_t                  head_ent;

    assign busy           = (state != ST_IDLE) && (state != ST_DONE);
    assign done           = (state == ST_DONE);
    assign particle_count = cnt_n;
    assign q_cnt          = bus.mem_q[ADDR_WIDTH-1:0];

    assign bus.wb_ready = busy && (state != ST_RD_CNT) && (state != ST_WAIT_CNT);
    assign wb_fire      = bus.wb_valid && bus.wb_ready;
    assign wb_ok        = (bus.wb_index != '0) && (bus.wb_index <= cnt_n);
    assign wr_en        = wb_fire && wb_ok;

    // buffered + in-flight must stay below 2 so every return has a slot
    assign occ      = {1'b0, fifo_cnt} + {2'b0, vld_pipe[STAGES]};
    assign rd_issue = (state == ST_STREAM) && !wb_fire && (occ < 3'd2);

    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign bus.out_index = bus.out_valid ? head_ent.index : '0;
    assign bus.out_vel   = bus.out_valid ? head_ent.vel   : '0;
    assign pop           = bus.out_valid && bus.out_ready;

    assign push_ent.index = rd_idx;
    assign push_ent.vel   = bus.mem_q;

    // single RAM port mux: write-back, count read, stream read, else idle
    always_comb begin
        bus.mem_rden    = 1'b0;
        bus.mem_wren    = 1'b0;
        bus.mem_address = '0;
        bus.mem_data    = '0;
        if (wr_en) begin
            bus.mem_wren    = 1'b1;
            bus.mem_address = bus.wb_index;
            bus.mem_data    = bus.wb_vel;
        end else if (state == ST_RD_CNT) begin
            bus.mem_rden    = 1'b1;
            bus.mem_address = ADDR_WIDTH'(COUNT_ADDR);
        end else if (rd_issue) begin
            bus.mem_rden    = 1'b1;
            bus.mem_address = rd_ptr;
        end
    end

    // sequencer FSM, counters, read-return tracking and sticky error
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            err      <= 1'b0;
            cnt_n    <= '0;
            rd_ptr   <= '0;
            rd_idx   <= '0;
            wb_cnt   <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_issue;
            if (rd_issue)
                rd_idx <= rd_ptr;
            if (wb_fire) begin
                if (wb_ok)
                    wb_cnt <= wb_cnt + 1'b1;
                else
                    err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RD_CNT;
                        err    <= 1'b0;
                        wb_cnt <= '0;
                    end
                end
                ST_RD_CNT: state <= ST_WAIT_CNT;
                ST_WAIT_CNT: begin
                    rd_ptr <= ADDR_WIDTH'(1);
                    if (q_cnt > MAX_N) begin
                        cnt_n <= MAX_N;
                        err   <= 1'b1;
                        state <= ST_STREAM;
                    end else begin
                        cnt_n <= q_cnt;
                        state <= (q_cnt == '0) ? ST_DONE : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (rd_issue) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        if (rd_ptr == cnt_n)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((fifo_cnt == 2'd0) && !vld_pipe[STAGES] &&
                        (wb_cnt == {1'b0, cnt_n}))
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    vel_stream_fifo2 #(.W($bits(ent_t))) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_pipe[STAGES]),
        .push_data (push_ent),
        .pop       (pop),
        .head      (head_ent),
        .count     (fifo_cnt)
    );

endmodule

// File: tb/tb_velocity_cell_stream_ctrl.sv
// Directed bench for velocity_cell_stream_ctrl with a behavioural 1-cycle RAM.
module tb_velocity_cell_stream_ctrl;
    import velocity_cell_stream_ctrl_pkg::*;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] particle_count;

    velocity_cell_stream_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    velocity_cell_stream_ctrl #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .particle_count (particle_count),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:PN-1];
    int checks = 0;
    int failures = 0;
    logic [AW-1:0] got_idx [$];
    logic [DW-1:0] got_vel [$];
    int overlap = 0, wr_cnt = 0, rd_cnt = 0, vld_cycles = 0, max_occ = 0;

    // single-port RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_wren && bus.mem_address < PN) ram[bus.mem_address] = bus.mem_data;
        if (bus.mem_rden) bus.mem_q <= (bus.mem_address < PN) ? ram[bus.mem_address] : '0;
    end

    // observe stream handshakes and port usage away from the active edge
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            got_idx.push_back(bus.out_index);
            got_vel.push_back(bus.out_vel);
        end
        if (bus.out_valid) vld_cycles++;
        if (bus.mem_rden && bus.mem_wren) overlap++;
        if (bus.mem_wren) wr_cnt++;
        if (bus.mem_rden) rd_cnt++;
        if (int'(u_dut.fifo_cnt) > max_occ) max_occ = int'(u_dut.fifo_cnt);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic clear_obs();
        got_idx.delete(); got_vel.delete();
        overlap = 0; wr_cnt = 0; rd_cnt = 0; vld_cycles = 0; max_occ = 0;
    endtask

    task automatic wb_send(input logic [AW-1:0] idx, input logic [DW-1:0] v, output bit ok);
        bus.wb_valid = 1'b1; bus.wb_index = idx; bus.wb_vel = v; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.wb_ready) ok = 1'b1;
            tick();
        end
        bus.wb_valid = 1'b0;
    endtask

    task automatic wait_stream(input int n, input int budget);
        for (int i = 0; i < budget && got_idx.size() < n; i++) tick();
    endtask

    task automatic wait_done(input int budget, output int cyc);
        bit seen;
        seen = 1'b0; cyc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; cyc = i; end
        end
        tick();
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b0; bus.wb_valid = 1'b1; bus.wb_index = 8'd5; bus.wb_vel = '1; bus.out_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({busy, done, err, bus.mem_rden, bus.mem_wren, bus.out_valid, bus.wb_ready} !== 7'b0) begin
            failures++; $display("FAIL reset_flags got=%b want=0000000",
                {busy, done, err, bus.mem_rden, bus.mem_wren, bus.out_valid, bus.wb_ready});
        end
        checks++;
        if (particle_count !== 8'd0 || bus.mem_address !== 8'd0 || bus.mem_data !== 96'd0) begin
            failures++; $display("FAIL reset_data cnt=%0h addr=%0h data=%0h want 0", particle_count, bus.mem_address, bus.mem_data);
        end
        checks++;
        if (bus.out_index !== 8'd0 || bus.out_vel !== 96'd0) begin
            failures++; $display("FAIL reset_out idx=%0h vel=%0h want 0", bus.out_index, bus.out_vel);
        end
        tick(); rst = 1'b1; tick();
        // write-back offered while IDLE must stall
        @(negedge clk);
        checks++;
        if (bus.wb_ready !== 1'b0 || bus.mem_wren !== 1'b0) begin
            failures++; $display("FAIL idle_wb_stall wb_ready=%b mem_wren=%b want 0 0", bus.wb_ready, bus.mem_wren);
        end
        tick(); bus.wb_valid = 1'b0;
        ok = 1'b0;
    endtask

    task automatic test_basic();
        bit ok; int nok, bad, cyc;
        ram[0] = 96'd3;
        for (int i = 1; i <= 3; i++) ram[i] = 96'(i) * 96'h111;
        clear_obs(); bus.out_ready = 1'b1;
        do_start();
        wait_stream(3, 40);
        checks++;
        if (got_idx.size() != 3) begin
            failures++; $display("FAIL basic_count got=%0d want=3", got_idx.size());
        end
        bad = 0;
        for (int i = 0; i < got_idx.size(); i++)
            if (got_idx[i] !== 8'(i + 1) || got_vel[i] !== 96'(i + 1) * 96'h111) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL basic_stream bad_words=%0d want=0", bad); end
        checks++;
        if (particle_count !== 8'd3) begin failures++; $display("FAIL basic_pcount got=%0d want=3", particle_count); end
        nok = 0;
        for (int i = 1; i <= 3; i++) begin
            wb_send(8'(i), 96'hA000 + 96'(i), ok);
            if (!ok) nok++;
        end
        wait_done(20, cyc);
        checks++;
        if (cyc < 0 || nok != 0) begin failures++; $display("FAIL basic_done cyc=%0d wb_timeouts=%0d want done,0", cyc, nok); end
        checks++;
        if (ram[1] !== 96'hA001 || ram[2] !== 96'hA002 || ram[3] !== 96'hA003) begin
            failures++; $display("FAIL basic_ram got=%0h,%0h,%0h want=a001,a002,a003", ram[1], ram[2], ram[3]);
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_flags err=%b busy=%b want 0 0", err, busy); end
    endtask

    task automatic test_count_zero();
        int cyc;
        ram[0] = 96'd0;
        clear_obs();
        do_start();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus.mem_rden !== 1'b1 || bus.mem_address !== 8'd0) begin
            failures++; $display("FAIL zero_rdcnt busy=%b rden=%b addr=%0h want 1 1 0", busy, bus.mem_rden, bus.mem_address);
        end
        tick();
        wait_done(10, cyc);
        checks++;
        if (cyc != 1) begin failures++; $display("FAIL zero_latency got=%0d want=1 (done 3 cycles after start)", cyc); end
        checks++;
        if (vld_cycles != 0 || wr_cnt != 0 || err !== 1'b0) begin
            failures++; $display("FAIL zero_quiet valid=%0d writes=%0d err=%b want 0 0 0", vld_cycles, wr_cnt, err);
        end
    endtask

    task automatic test_clamp();
        bit ok; int nok, bad, cyc;
        ram[0] = 96'd250;
        for (int i = 1; i < PN; i++) ram[i] = 96'(i) * 96'h111;
        clear_obs(); bus.out_ready = 1'b1;
        do_start(); tick(); tick();
        @(negedge clk);
        checks++;
        if (particle_count !== 8'd219 || err !== 1'b1) begin
            failures++; $display("FAIL clamp_latch cnt=%0d err=%b want 219 1", particle_count, err);
        end
        wait_stream(219, 2000);
        tick(); tick(); tick();
        checks++;
        if (got_idx.size() != 219) begin failures++; $display("FAIL clamp_words got=%0d want=219", got_idx.size()); end
        bad = 0;
        for (int i = 0; i < got_idx.size(); i++)
            if (got_idx[i] !== 8'(i + 1) || got_vel[i] !== 96'(i + 1) * 96'h111) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL clamp_order bad_words=%0d want=0", bad); end
        nok = 0;
        for (int i = 1; i <= 219; i++) begin
            wb_send(8'(i), 96'(i), ok);
            if (!ok) nok++;
        end
        wait_done(20, cyc);
        checks++;
        if (cyc < 0 || nok != 0 || err !== 1'b1) begin
            failures++; $display("FAIL clamp_done cyc=%0d wb_timeouts=%0d err=%b want done,0,1", cyc, nok, err);
        end
    endtask

    task automatic test_backpressure();
        bit ok; int nok, bad, cyc;
        logic [39:0] pat;
        pat = 40'hB6_D9_5A_3C_E7;
        ram[0] = 96'd5;
        for (int i = 1; i <= 5; i++) ram[i] = pack_vel(32'h1000 + i, 32'h2000 + i, 32'h3000 + i);
        clear_obs(); bus.out_ready = 1'b0;
        do_start();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL bp_err_cleared got=%b want=0", err); end
        tick();
        for (int k = 0; k < 300 && got_idx.size() < 5; k++) begin
            bus.out_ready = (k >= 2 && k < 12) ? 1'b0 : pat[k % 40];
            tick();
        end
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (got_idx.size() != 5) begin failures++; $display("FAIL bp_words got=%0d want=5", got_idx.size()); end
        bad = 0;
        for (int i = 0; i < got_idx.size(); i++)
            if (got_idx[i] !== 8'(i + 1) || got_vel[i] !== pack_vel(32'h1000 + i + 1, 32'h2000 + i + 1, 32'h3000 + i + 1)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_order bad_words=%0d want=0", bad); end
        checks++;
        if (max_occ > 2) begin failures++; $display("FAIL bp_occupancy got=%0d want<=2", max_occ); end
        nok = 0;
        for (int i = 1; i <= 5; i++) begin
            wb_send(8'(i), 96'hB00 + 96'(i), ok);
            if (!ok) nok++;
        end
        wait_done(20, cyc);
        checks++;
        if (cyc < 0 || nok != 0) begin failures++; $display("FAIL bp_done cyc=%0d wb_timeouts=%0d want done,0", cyc, nok); end
    endtask

    task automatic test_wb_priority();
        int bad, cyc;
        ram[0] = 96'd4;
        for (int i = 1; i <= 4; i++) ram[i] = 96'hC00 + 96'(i);
        clear_obs(); bus.out_ready = 1'b1;
        do_start();
        bad = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (bus.wb_ready !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wbp_cnt_phase_stall ready_cycles=%0d want=0", bad); end
        // now in STREAM: hold write-backs every cycle
        rd_cnt = 0; bad = 0;
        for (int k = 1; k <= 4; k++) begin
            bus.wb_valid = 1'b1; bus.wb_index = 8'(k); bus.wb_vel = 96'hD00 + 96'(k);
            @(negedge clk);
            if (!(bus.wb_ready === 1'b1 && bus.mem_wren === 1'b1 && bus.mem_rden === 1'b0)) bad++;
            tick();
        end
        bus.wb_valid = 1'b0;
        checks++;
        if (bad != 0 || rd_cnt != 0) begin
            failures++; $display("FAIL wbp_hold bad_cycles=%0d reads=%0d want 0 0", bad, rd_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.mem_rden !== 1'b1 || bus.mem_address !== 8'd1) begin
            failures++; $display("FAIL wbp_resume rden=%b addr=%0h want 1 1", bus.mem_rden, bus.mem_address);
        end
        tick();
        wait_stream(4, 40);
        bad = 0;
        for (int i = 0; i < got_idx.size(); i++)
            if (got_idx[i] !== 8'(i + 1) || got_vel[i] !== 96'hD00 + 96'(i + 1)) bad++;
        checks++;
        if (got_idx.size() != 4 || bad != 0) begin
            failures++; $display("FAIL wbp_stream words=%0d bad=%0d want 4 0", got_idx.size(), bad);
        end
        wait_done(20, cyc);
        checks++;
        if (cyc < 0 || overlap != 0) begin failures++; $display("FAIL wbp_done cyc=%0d overlap=%0d want done,0", cyc, overlap); end
    endtask

    task automatic test_bad_wb();
        bit ok0, ok1, ok2, ok3; int w0, cyc;
        logic [DW-1:0] r3;
        ram[0] = 96'd2; ram[1] = 96'h51; ram[2] = 96'h52; ram[3] = 96'h53;
        r3 = ram[3];
        clear_obs(); bus.out_ready = 1'b1;
        do_start();
        wait_stream(2, 40);
        tick(); tick();
        w0 = wr_cnt;
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL badwb_pre_err got=%b want=0", err); end
        wb_send(8'd0, 96'hDEAD, ok0);
        @(negedge clk);
        checks++;
        if (!ok0 || wr_cnt != w0 || err !== 1'b1) begin
            failures++; $display("FAIL badwb_idx0 ack=%b writes=%0d err=%b want 1 %0d 1", ok0, wr_cnt, err, w0);
        end
        tick();
        wb_send(8'd3, 96'hBEEF, ok1);
        checks++;
        if (!ok1 || wr_cnt != w0 || ram[0] !== 96'd2 || ram[3] !== r3) begin
            failures++; $display("FAIL badwb_idx_n1 ack=%b writes=%0d ram0=%0h ram3=%0h want 1 %0d 2 %0h", ok1, wr_cnt, ram[0], ram[3], w0, r3);
        end
        wb_send(8'd1, 96'hE1, ok2);
        wait_done(6, cyc);
        checks++;
        if (cyc != -1) begin failures++; $display("FAIL badwb_cnt_unchanged done_at=%0d want none", cyc); end
        wb_send(8'd2, 96'hE2, ok3);
        wait_done(10, cyc);
        checks++;
        if (cyc < 0 || !ok2 || !ok3 || wr_cnt != w0 + 2) begin
            failures++; $display("FAIL badwb_finish cyc=%0d writes=%0d want done %0d", cyc, wr_cnt, w0 + 2);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int cyc;
        ram[0] = 96'd6;
        for (int i = 1; i <= 6; i++) ram[i] = 96'hF0 + 96'(i);
        clear_obs(); bus.out_ready = 1'b0;
        do_start();
        for (int k = 0; k < 6; k++) tick();
        rst = 1'b0; tick();
        @(negedge clk);
        checks++;
        if ({busy, done, err, bus.mem_rden, bus.mem_wren, bus.out_valid, bus.wb_ready} !== 7'b0 ||
            bus.out_index !== 8'd0 || bus.out_vel !== 96'd0 || bus.mem_address !== 8'd0 || particle_count !== 8'd0) begin
            failures++; $display("FAIL midrst_outputs flags=%b idx=%0h cnt=%0d want all 0",
                {busy, done, err, bus.mem_rden, bus.mem_wren, bus.out_valid, bus.wb_ready}, bus.out_index, particle_count);
        end
        rst = 1'b1; rd_cnt = 0; wr_cnt = 0;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (rd_cnt != 0 || wr_cnt != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL midrst_quiet reads=%0d writes=%0d busy=%b want 0 0 0", rd_cnt, wr_cnt, busy);
        end
        // fresh one-word pass must not see stale buffered data
        ram[0] = 96'd1; ram[1] = 96'h777;
        clear_obs(); bus.out_ready = 1'b1;
        do_start();
        wait_stream(1, 40);
        tick(); tick(); tick();
        checks++;
        if (got_idx.size() != 1 || got_idx[0] !== 8'd1 || got_vel[0] !== 96'h777) begin
            failures++; $display("FAIL midrst_fresh words=%0d first_idx=%0h want 1 1",
                got_idx.size(), (got_idx.size() > 0) ? got_idx[0] : 8'hFF);
        end
        wb_send(8'd1, 96'h778, ok);
        wait_done(10, cyc);
        checks++;
        if (cyc < 0 || !ok) begin failures++; $display("FAIL midrst_done cyc=%0d ack=%b want done 1", cyc, ok); end
    endtask

    initial begin
        bus.out_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_index = '0; bus.wb_vel = '0;
        for (int i = 0; i < PN; i++) ram[i] = '0;
        test_reset();
        test_basic();
        test_count_zero();
        test_clamp();
        test_backpressure();
        test_wb_priority();
        test_bad_wb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/velocity_cell_stream_ctrl.md
Name: velocity_cell_stream_ctrl

Overview:
Sequencer between one velocity cell RAM (single-port, 1-cycle read latency, address 0 = particle count, addresses 1..N = {vz,vy,vx}) and the motion-update pipeline. On start, it reads the count, then streams every stored velocity out with valid/ready backpressure. It also accepts updated velocities from motion update and writes them back into the same single port. Write-backs take priority over streaming reads.

Parameters:
DATA_WIDTH, 96, velocity word width {vz,vy,vx}, 3x FP32
PARTICLE_NUM, 220, RAM depth in words, including the count word
ADDR_WIDTH, 8, RAM address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins a pass; ignored unless IDLE
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at pass completion
err  out  1  sticky error flag; cleared by the next accepted start
particle_count  out  ADDR_WIDTH  count latched from address 0 (after clamping)
mem_address  out  ADDR_WIDTH  to RAM address
mem_data  out  DATA_WIDTH  to RAM write data
mem_rden  out  1  RAM read enable
mem_wren  out  1  RAM write enable
mem_q  in  DATA_WIDTH  RAM read data, valid 1 cycle after rden
out_valid  out  1  stream data valid
out_ready  in  1  downstream accept
out_index  out  ADDR_WIDTH  particle address (1..N) of out_vel
out_vel  out  DATA_WIDTH  velocity word
wb_valid  in  1  write-back request
wb_ready  out  1  write-back accepted this cycle
wb_index  in  ADDR_WIDTH  particle address to write
wb_vel  in  DATA_WIDTH  updated velocity

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE.
  - busy, done, err, mem_rden, mem_wren, out_valid and wb_ready are 0.
  - particle_count, mem_address, mem_data, out_index and out_vel are 0.
  - The output FIFO and all counters are cleared.
  - Reset mid-pass abandons the pass; no further RAM access is issued.
- States:
  - IDLE: on start, go to RD_CNT; busy=1; err cleared.
  - RD_CNT: mem_rden=1, address 0. Next state WAIT_CNT.
  - WAIT_CNT: latch mem_q[ADDR_WIDTH-1:0] as N.
    - If N > PARTICLE_NUM-1: clamp N to PARTICLE_NUM-1 and set err.
    - If N==0: go to DONE. Otherwise go to STREAM with rd_ptr=1.
  - STREAM: issue reads for rd_ptr = 1..N under the arbitration rules below. After the read at N is issued, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and wb_cnt==N, then go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Output buffer:
  - 2-entry FIFO holding {index, vel}; out_valid = FIFO not empty.
  - Pop on out_valid & out_ready.
  - A read is issued only if (FIFO occupancy + reads in flight) < 2. This guarantees no data is lost under any out_ready pattern.
  - Returned mem_q is pushed 1 cycle after its rden.
- Single-port arbitration, per cycle:
  - wb_ready = busy & state not in {RD_CNT, WAIT_CNT}.
  - If wb_valid & wb_ready: write wins. mem_wren=1, mem_address=wb_index, mem_data=wb_vel, no read issued that cycle.
  - mem_rden and mem_wren are never both 1.
- Write-back rules:
  - wb_index==0 or wb_index > N: write suppressed (mem_wren=0), handshake still completes, err set, wb_cnt not incremented.
  - Valid write-backs increment wb_cnt (ADDR_WIDTH+1 bits).
  - Writing an index not yet streamed is legal. The later read returns the written value.
  - wb_valid while IDLE: wb_ready=0 (stalled).
- Ordering: out_index is strictly increasing 1..N with no gaps or duplicates.
- start while busy: ignored, no effect.

Decomposition:
- Shared package/define header:
  - State encoding constants.
  - Field slice constants VX=[31:0], VY=[63:32], VZ=[95:64].
  - COUNT_ADDR=0.
- One sub-module: vel_stream_fifo2, a 2-deep FIFO with count output.

Test Plan:
- RAM count=3, vel[i]=i*0x111, out_ready=1 always -> out_index 1,2,3 with matching vel.
  - Write back 3 values -> done pulse; RAM holds the new values; err=0.
- count=0 -> done 3 cycles after start; no out_valid; no writes; err=0.
- count=250 (>219) -> particle_count=219, err=1; exactly 219 words streamed.
- count=5, out_ready toggling randomly (including 10-cycle low) -> all 5 delivered in order; FIFO never exceeds 2; no duplicates.
- wb_valid held every cycle during STREAM -> reads stall while writes proceed.
  - mem_rden and mem_wren are never both high.
  - Streaming resumes when wb_valid drops.
- wb_index=0 and wb_index=N+1 -> no mem_wren, err=1, wb_cnt unchanged.
  - Reset asserted mid-STREAM -> all outputs 0 next cycle; IDLE.
